// File: rtl/tcm_arb_pkg.sv
// Shared types and sizing helpers for the TCM port-1 arbiter.
package tcm_arb_pkg;

   localparam int unsigned TAG_W  = 11;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned RAM_DW = 64;
   localparam int unsigned STRB_W = 4;

   // 64-bit word address width for a TCM of depth_kb KByte
   function automatic int unsigned ram_aw(input int unsigned depth_kb);
      return $clog2(depth_kb * 128);
   endfunction

   // Source of the response currently in the ack stage
   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_EXT = 1'b1
   } tcm_owner_e;

endpackage

// File: rtl/tcm_port_arbiter_if.sv
// Bundle of CPU, external and RAM port-1 signals around the arbiter.
// slave: arbiter side; master: requesters plus RAM side.
interface tcm_port_arbiter_if
   import tcm_arb_pkg::*;
#(
   parameter int unsigned TCM_MEM_DEPTH = 16
);

   localparam int unsigned RAM_AW = ram_aw(TCM_MEM_DEPTH);

   logic                cpu_rd_i;
   logic [STRB_W-1:0]   cpu_wr_i;
   logic                cpu_cmo_i;
   logic [WORD_W-1:0]   cpu_addr_i;
   logic [WORD_W-1:0]   cpu_data_wr_i;
   logic [TAG_W-1:0]    cpu_tag_i;
   logic                cpu_accept_o;
   logic                cpu_ack_o;
   logic [TAG_W-1:0]    cpu_tag_o;
   logic [WORD_W-1:0]   cpu_data_rd_o;

   logic                ext_rd_i;
   logic [STRB_W-1:0]   ext_wr_i;
   logic [WORD_W-1:0]   ext_addr_i;
   logic [WORD_W-1:0]   ext_data_wr_i;
   logic                ext_accept_o;
   logic                ext_ack_o;
   logic [WORD_W-1:0]   ext_data_rd_o;

   logic [RAM_AW-1:0]   ram_addr_o;
   logic [RAM_DW-1:0]   ram_data_o;
   logic [2*STRB_W-1:0] ram_wr_o;
   logic [RAM_DW-1:0]   ram_data_i;

   modport slave (
      input  cpu_rd_i, cpu_wr_i, cpu_cmo_i, cpu_addr_i, cpu_data_wr_i, cpu_tag_i,
      output cpu_accept_o, cpu_ack_o, cpu_tag_o, cpu_data_rd_o,
      input  ext_rd_i, ext_wr_i, ext_addr_i, ext_data_wr_i,
      output ext_accept_o, ext_ack_o, ext_data_rd_o,
      output ram_addr_o, ram_data_o, ram_wr_o,
      input  ram_data_i
   );

   modport master (
      output cpu_rd_i, cpu_wr_i, cpu_cmo_i, cpu_addr_i, cpu_data_wr_i, cpu_tag_i,
      input  cpu_accept_o, cpu_ack_o, cpu_tag_o, cpu_data_rd_o,
      output ext_rd_i, ext_wr_i, ext_addr_i, ext_data_wr_i,
      input  ext_accept_o, ext_ack_o, ext_data_rd_o,
      input  ram_addr_o, ram_data_o, ram_wr_o,
      output ram_data_i
   );

endinterface

// File: rtl/tcm_port_arbiter.sv
// Arbiter for the shared 64-bit TCM data port (port 1) between the LSU and
// the external (AXI->PMEM) side. External wins by default; with
// TCM_ARB_STARVE_GUARD_EN defined, the CPU is forced through after
// MAX_EXT_RUN consecutive external grants while it waits.
module tcm_port_arbiter
   import tcm_arb_pkg::*;
#(
   parameter int unsigned TCM_MEM_DEPTH = 16,
   parameter int unsigned MAX_EXT_RUN   = 4
)(
   input  logic               clk_i,
   input  logic               rst_i,
   tcm_port_arbiter_if.slave  bus
);

   localparam int unsigned RAM_AW = ram_aw(TCM_MEM_DEPTH);

   if (MAX_EXT_RUN < 1) begin : g_bad_max_ext_run
      $error("MAX_EXT_RUN must be at least 1");
   end

   logic                cpu_req_w;
   logic                ext_req_w;
   logic                force_cpu_w;
   logic                cpu_acc_w;
   logic                ext_acc_w;
   logic [WORD_W-1:0]   addr_w;
   logic [WORD_W-1:0]   data_w;
   logic [STRB_W-1:0]   wr_w;
   logic                unused_addr_w;

   logic                ack_vld_q;
   tcm_owner_e          ack_src_q;
   logic [TAG_W-1:0]    tag_q;
   logic                sel_hi_q;

   assign cpu_req_w = bus.cpu_rd_i | (|bus.cpu_wr_i) | bus.cpu_cmo_i;
   assign ext_req_w = bus.ext_rd_i | (|bus.ext_wr_i);

`ifdef TCM_ARB_STARVE_GUARD_EN
   localparam int unsigned RUN_W = $clog2(MAX_EXT_RUN + 1);

   logic [RUN_W-1:0]    ext_run_q;

   // Count external grants that overtake a waiting CPU request
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ext_run_q <= '0;
      end else if (cpu_acc_w || !cpu_req_w) begin
         ext_run_q <= '0;
      end else if (ext_acc_w) begin
         ext_run_q <= ext_run_q + RUN_W'(1);
      end
   end

   assign force_cpu_w = cpu_req_w & (ext_run_q == RUN_W'(MAX_EXT_RUN));
`else
   assign force_cpu_w = 1'b0;
`endif

   // Grant and port-1 request mux; address/data default to the CPU side
   always_comb begin
      cpu_acc_w = cpu_req_w & (~ext_req_w | force_cpu_w);
      ext_acc_w = ext_req_w & ~cpu_acc_w;
      addr_w    = bus.cpu_addr_i;
      data_w    = bus.cpu_data_wr_i;
      wr_w      = cpu_acc_w ? bus.cpu_wr_i : '0;
      if (ext_acc_w) begin
         addr_w = bus.ext_addr_i;
         data_w = bus.ext_data_wr_i;
         wr_w   = bus.ext_wr_i;
      end
   end

   assign bus.cpu_accept_o = cpu_acc_w;
   assign bus.ext_accept_o = ext_acc_w;
   assign bus.ram_addr_o   = addr_w[RAM_AW+2:3];
   assign bus.ram_data_o   = {data_w, data_w};
   assign bus.ram_wr_o     = addr_w[2] ? {wr_w, STRB_W'(0)} : {STRB_W'(0), wr_w};
   assign unused_addr_w    = ^{addr_w[WORD_W-1:RAM_AW+3], addr_w[1:0]};

   // Response stage: one cycle behind the accept, matching RAM read latency
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ack_vld_q <= 1'b0;
         ack_src_q <= OWN_CPU;
         tag_q     <= '0;
         sel_hi_q  <= 1'b0;
      end else begin
         ack_vld_q <= cpu_acc_w | ext_acc_w;
         ack_src_q <= ext_acc_w ? OWN_EXT : OWN_CPU;
         sel_hi_q  <= addr_w[2];
         if (cpu_acc_w) begin
            tag_q <= bus.cpu_tag_i;
         end
      end
   end

   assign bus.cpu_ack_o     = ack_vld_q & (ack_src_q == OWN_CPU);
   assign bus.ext_ack_o     = ack_vld_q & (ack_src_q == OWN_EXT);
   assign bus.cpu_tag_o     = tag_q;
   assign bus.cpu_data_rd_o = sel_hi_q ? bus.ram_data_i[RAM_DW-1:WORD_W]
                                       : bus.ram_data_i[WORD_W-1:0];
   assign bus.ext_data_rd_o = bus.cpu_data_rd_o;

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Bench for tcm_port_arbiter: directed scenarios followed by a random
// request stream compared against a transaction-level reference model.
// Honours TCM_ARB_STARVE_GUARD_EN the same way the design does.
module tb_tcm_port_arbiter;
   import tcm_arb_pkg::*;

   localparam int unsigned DEPTH   = 16;
   localparam int unsigned MAX_RUN = 4;
   localparam int unsigned AW      = ram_aw(DEPTH);
`ifdef TCM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   typedef struct {
      bit          vld;
      bit          rd;
      bit          cmo;
      logic [3:0]  wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [10:0] tag;
   } req_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   tcm_port_arbiter_if #(.TCM_MEM_DEPTH(DEPTH)) bus ();

   tcm_port_arbiter #(
      .TCM_MEM_DEPTH (DEPTH),
      .MAX_EXT_RUN   (MAX_RUN)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   int unsigned ntot = 0;
   int unsigned nbad = 0;
   req_t        none = '{default: '0};

   // Count one comparison; report it when it differs
   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      ntot++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic req_t mk(input bit rd, input logic [3:0] wr, input bit cmo,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [10:0] tag);
      req_t r;
      r.vld = 1'b1; r.rd = rd; r.wr = wr; r.cmo = cmo;
      r.addr = addr; r.data = data; r.tag = tag;
      return r;
   endfunction

   task automatic drive(input req_t c, input req_t e);
      bus.cpu_rd_i      = c.vld & c.rd;
      bus.cpu_wr_i      = c.vld ? c.wr : 4'h0;
      bus.cpu_cmo_i     = c.vld & c.cmo;
      bus.cpu_addr_i    = c.vld ? c.addr : 32'h0;
      bus.cpu_data_wr_i = c.vld ? c.data : 32'h0;
      bus.cpu_tag_i     = c.vld ? c.tag : 11'h0;
      bus.ext_rd_i      = e.vld & e.rd;
      bus.ext_wr_i      = e.vld ? e.wr : 4'h0;
      bus.ext_addr_i    = e.vld ? e.addr : 32'h0;
      bus.ext_data_wr_i = e.vld ? e.data : 32'h0;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Expected RAM byte strobes for a granted request
   function automatic logic [7:0] lane_strb(input req_t r);
      logic [7:0] s;
      s = (r.rd || r.cmo) ? 8'h00 : {4'h0, r.wr};
      return r.addr[2] ? (s << 4) : s;
   endfunction

   initial begin
      req_t cc, ee, g;
      bit   exp_cpu;
      bit   do_rst, cpu_go, ext_go, force_cpu;
      bit   p_cpu, p_ext, p_rd, p_hi;
      logic [10:0] p_tag;
      logic [31:0] exp_rd;
      int   cpu_wait;

      drive(none, none);
      bus.ram_data_i = 64'h0;
      rst_i = 1'b1;

      // Reset state and low-lane read data after reset
      tick(); tick();
      bus.ram_data_i = 64'h1111_2222_3333_4444;
      #1;
      chk("rst_cpu_ack", 64'(bus.cpu_ack_o), 64'h0);
      chk("rst_ext_ack", 64'(bus.ext_ack_o), 64'h0);
      chk("rst_tag", 64'(bus.cpu_tag_o), 64'h0);
      chk("rst_data_lo", 64'(bus.cpu_data_rd_o), 64'h3333_4444);
      rst_i = 1'b0;

      // CPU read from the high lane
      tick();
      drive(mk(1'b1, 4'h0, 1'b0, 32'h0000_0104, 32'h0, 11'h02A), none);
      #1;
      chk("t1_cpu_acc", 64'(bus.cpu_accept_o), 64'h1);
      chk("t1_ext_acc", 64'(bus.ext_accept_o), 64'h0);
      chk("t1_ram_addr", 64'(bus.ram_addr_o), 64'h20);
      chk("t1_ram_wr", 64'(bus.ram_wr_o), 64'h0);
      tick();
      drive(none, none);
      bus.ram_data_i = 64'hAAAA_BBBB_CCCC_DDDD;
      #1;
      chk("t1_cpu_ack", 64'(bus.cpu_ack_o), 64'h1);
      chk("t1_tag", 64'(bus.cpu_tag_o), 64'h02A);
      chk("t1_data_hi", 64'(bus.cpu_data_rd_o), 64'hAAAA_BBBB);
      chk("t1_ext_ack", 64'(bus.ext_ack_o), 64'h0);

      // Simultaneous writes: ext first, CPU next cycle
      drive(mk(1'b0, 4'hF, 1'b0, 32'h4, 32'h1234_5678, 11'h011),
            mk(1'b0, 4'hF, 1'b0, 32'h0, 32'h9ABC_DEF0, 11'h0));
      #1;
      chk("t2_ext_acc", 64'(bus.ext_accept_o), 64'h1);
      chk("t2_cpu_acc", 64'(bus.cpu_accept_o), 64'h0);
      chk("t2_ram_wr_ext", 64'(bus.ram_wr_o), 64'h0F);
      chk("t2_ram_data", bus.ram_data_o, 64'h9ABC_DEF0_9ABC_DEF0);
      tick();
      drive(mk(1'b0, 4'hF, 1'b0, 32'h4, 32'h1234_5678, 11'h011), none);
      #1;
      chk("t2_cpu_acc2", 64'(bus.cpu_accept_o), 64'h1);
      chk("t2_ram_wr_cpu", 64'(bus.ram_wr_o), 64'hF0);
      chk("t2_ext_ack", 64'(bus.ext_ack_o), 64'h1);
      tick();
      drive(none, none);
      #1;
      chk("t2_cpu_ack", 64'(bus.cpu_ack_o), 64'h1);
      chk("t2_tag", 64'(bus.cpu_tag_o), 64'h011);

      // Ext partial write, data replicated into both lanes
      drive(none, mk(1'b0, 4'b0011, 1'b0, 32'h8, 32'hDEAD_BEEF, 11'h0));
      #1;
      chk("t3_ram_wr", 64'(bus.ram_wr_o), 64'h03);
      chk("t3_ram_data", bus.ram_data_o, 64'hDEAD_BEEF_DEAD_BEEF);
      chk("t3_ram_addr", 64'(bus.ram_addr_o), 64'h1);
      tick();
      drive(none, none);
      #1;
      chk("t3_ext_ack", 64'(bus.ext_ack_o), 64'h1);
      chk("t3_cpu_ack", 64'(bus.cpu_ack_o), 64'h0);

      // Cache maintenance: accepted, no RAM write, acked with tag
      drive(mk(1'b0, 4'h0, 1'b1, 32'h10, 32'h0, 11'h155), none);
      #1;
      chk("t5_cpu_acc", 64'(bus.cpu_accept_o), 64'h1);
      chk("t5_ram_wr", 64'(bus.ram_wr_o), 64'h0);
      tick();
      drive(none, none);
      #1;
      chk("t5_cpu_ack", 64'(bus.cpu_ack_o), 64'h1);
      chk("t5_tag", 64'(bus.cpu_tag_o), 64'h155);

      // Reset during an ext read accept discards it
      drive(none, mk(1'b1, 4'h0, 1'b0, 32'h20, 32'h0, 11'h0));
      rst_i = 1'b1;
      #1;
      chk("t6_ext_acc", 64'(bus.ext_accept_o), 64'h1);
      tick();
      rst_i = 1'b0;
      drive(none, none);
      #1;
      chk("t6_ext_ack", 64'(bus.ext_ack_o), 64'h0);
      chk("t6_cpu_ack", 64'(bus.cpu_ack_o), 64'h0);
      chk("t6_tag", 64'(bus.cpu_tag_o), 64'h0);

      // Ext streaming while the CPU waits
      cc = mk(1'b1, 4'h0, 1'b0, 32'h4, 32'h0, 11'h007);
      ee = mk(1'b1, 4'h0, 1'b0, 32'h0, 32'h0, 11'h0);
      tick();
      for (int cyc = 0; cyc < 6; cyc++) begin
         drive(cc, ee);
         #1;
         exp_cpu = GUARD && (cyc == int'(MAX_RUN));
         chk($sformatf("t4_cpu_acc_c%0d", cyc), 64'(bus.cpu_accept_o), 64'(exp_cpu));
         chk($sformatf("t4_ext_acc_c%0d", cyc), 64'(bus.ext_accept_o), 64'(!exp_cpu));
         if (exp_cpu) cc = none;
         tick();
      end
      drive(none, none);
      tick(); tick();

      // Random traffic against the transaction-level model
      cc = none; ee = none;
      p_cpu = 0; p_ext = 0; p_rd = 0; p_hi = 0; p_tag = '0;
      cpu_wait = 0;
      for (int n = 0; n < 3000; n++) begin
         do_rst = ($urandom_range(0, 99) < 2);
         if (!cc.vld && $urandom_range(0, 9) < 6) begin
            case ($urandom_range(0, 2))
               0:       cc = mk(1'b1, 4'h0, 1'b0, $urandom, $urandom, 11'($urandom));
               1:       cc = mk(1'b0, 4'($urandom_range(1, 15)), 1'b0, $urandom, $urandom, 11'($urandom));
               default: cc = mk(1'b0, 4'h0, 1'b1, $urandom, $urandom, 11'($urandom));
            endcase
            cpu_wait = 0;
         end
         if (!ee.vld && $urandom_range(0, 9) < 6) begin
            if ($urandom_range(0, 1) == 0)
               ee = mk(1'b1, 4'h0, 1'b0, $urandom, $urandom, 11'h0);
            else
               ee = mk(1'b0, 4'($urandom_range(1, 15)), 1'b0, $urandom, $urandom, 11'h0);
         end
         rst_i = do_rst;
         drive(cc, ee);
         bus.ram_data_i = {$urandom, $urandom};
         #1;

         // Response for whatever was accepted last cycle
         chk("r_cpu_ack", 64'(bus.cpu_ack_o), 64'(p_cpu));
         chk("r_ext_ack", 64'(bus.ext_ack_o), 64'(p_ext));
         exp_rd = p_hi ? bus.ram_data_i[63:32] : bus.ram_data_i[31:0];
         if (p_cpu) chk("r_tag", 64'(bus.cpu_tag_o), 64'(p_tag));
         if (p_cpu && p_rd) chk("r_cpu_data", 64'(bus.cpu_data_rd_o), 64'(exp_rd));
         if (p_ext && p_rd) chk("r_ext_data", 64'(bus.ext_data_rd_o), 64'(exp_rd));

         // Grant decision: ext first unless the CPU has waited its limit
         force_cpu = GUARD && cc.vld && (cpu_wait == int'(MAX_RUN));
         cpu_go    = cc.vld && (!ee.vld || force_cpu);
         ext_go    = ee.vld && !cpu_go;
         chk("r_cpu_acc", 64'(bus.cpu_accept_o), 64'(cpu_go));
         chk("r_ext_acc", 64'(bus.ext_accept_o), 64'(ext_go));
         if (cpu_go || ext_go) begin
            g = cpu_go ? cc : ee;
            chk("r_ram_addr", 64'(bus.ram_addr_o), 64'(AW'(g.addr >> 3)));
            chk("r_ram_wr", 64'(bus.ram_wr_o), 64'(lane_strb(g)));
            chk("r_ram_data", bus.ram_data_o, {g.data, g.data});
            p_rd  = g.rd;
            p_hi  = g.addr[2];
         end else begin
            chk("r_ram_wr_idle", 64'(bus.ram_wr_o), 64'h0);
         end
         p_cpu = cpu_go && !do_rst;
         p_ext = ext_go && !do_rst;
         if (cpu_go) p_tag = cc.tag;

         // Requesters retire accepted requests; CPU age tracks its wait
         if (cpu_go) begin
            cc = none;
            cpu_wait = 0;
         end else if (do_rst || !cc.vld) begin
            cpu_wait = 0;
         end else begin
            cpu_wait++;
         end
         if (ext_go) ee = none;
         tick();
      end
      rst_i = 1'b0;

      $display("test done: total=%0d bad=%0d", ntot, nbad);
      $finish;
   end

endmodule
